// File: rtl/iir_sample_sequencer_if.sv
// rtl/iir_sample_sequencer_if.sv - sample-in / result-out stream bundle for the IIR sample sequencer
interface iir_sample_sequencer_if #(
  parameter int INPUT_WIDTH  = 13,
  parameter int OUTPUT_WIDTH = 38
);
  logic                    s_valid;
  logic                    s_ready;
  logic [INPUT_WIDTH-1:0]  s_data;
  logic                    m_valid;
  logic                    m_ready;
  logic [OUTPUT_WIDTH-1:0] m_data;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/iir_sample_sequencer.sv
// rtl/iir_sample_sequencer.sv - paces iir_clken steps per sample, tags real samples, drains via zero-sample flush
module iir_sample_sequencer #(
  parameter int INPUT_WIDTH  = 13,
  parameter int OUTPUT_WIDTH = 38,
  parameter int LATENCY      = 3,
  parameter int MIN_GAP      = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  iir_sample_sequencer_if.slave   strm,
  input  logic                    flush_req,
  output logic                    iir_clken,
  output logic [INPUT_WIDTH-1:0]  iir_x,
  input  logic [OUTPUT_WIDTH-1:0] iir_result,
  output logic                    busy
);
  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(MIN_GAP - 1);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t             state_q, state_d;
  logic [LATENCY-1:0] tag_q, tag_d;
  logic               taken_q, taken_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  logic flush_active;
  logic m_valid_int;
  logic stall;
  logic can_step;
  logic step;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      tag_q   <= '0;
      taken_q <= 1'b0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      taken_q <= taken_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    flush_active = (state_q == ST_FLUSH);
    m_valid_int  = ~reset & tag_q[LATENCY-1] & ~taken_q;
    // Holding the filter still under backpressure keeps m_data stable.
    stall        = m_valid_int & ~strm.m_ready;
    can_step     = ~reset & (gap_q == '0) & ~stall;
    step         = can_step & (strm.s_valid | flush_active);

    state_d = state_q;
    tag_d   = tag_q;
    taken_d = taken_q;
    gap_d   = gap_q;

    if (step) begin
      tag_d   = {tag_q[LATENCY-2:0], ~flush_active};
      taken_d = 1'b0;
      gap_d   = GAP_RELOAD;
    end else begin
      if (gap_q != '0) gap_d = gap_q - GAP_W'(1);
      if (m_valid_int & strm.m_ready) taken_d = 1'b1;
    end

    // Flush decisions look at the tags as they will be after this cycle's step.
    case (state_q)
      ST_RUN:   if (flush_req && (tag_d[LATENCY-2:0] != '0)) state_d = ST_FLUSH;
      ST_FLUSH: if (tag_d[LATENCY-2:0] == '0) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  assign strm.s_ready = can_step & ~flush_active;
  assign strm.m_valid = m_valid_int;
  assign strm.m_data  = iir_result;
  assign iir_clken    = step;
  assign iir_x        = flush_active ? '0 : strm.s_data;
  // A taken final result no longer counts as in flight.
  assign busy         = ~reset & (flush_active | (|tag_q[LATENCY-2:0]) | m_valid_int);
endmodule
